// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage pipelined ARM core.
// Tracks E/M/W register addresses locally and counts load-use stalls and taken branches.
module hazard_unit #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  RA1D,
    input  logic [RA_W-1:0]  RA2D,
    input  logic [RA_W-1:0]  WA3D,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] LdStallCount,
    output logic [CNT_W-1:0] BrFlushCount
);

    logic [RA_W-1:0]  ra1_e_r;
    logic [RA_W-1:0]  ra2_e_r;
    logic [RA_W-1:0]  wa3_e_r;
    logic [RA_W-1:0]  wa3_m_r;
    logic [RA_W-1:0]  wa3_w_r;
    logic [CNT_W-1:0] ld_stall_cnt_r;
    logic [CNT_W-1:0] br_flush_cnt_r;

    logic             ld_stall_s;
    logic             pc_wr_pend_s;
    logic             flush_e_s;

    // Memory stage wins over Writeback; R15 is deliberately not excluded.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic [RA_W-1:0] wa_m,
        input logic [RA_W-1:0] wa_w,
        input logic            we_m,
        input logic            we_w
    );
        logic [1:0] sel;
        if (we_m && (ra == wa_m)) begin
            sel = 2'b10;
        end else if (we_w && (ra == wa_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (cnt == {CNT_W{1'b1}}) begin
            nxt = cnt;
        end else begin
            nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Stall, flush and forwarding decisions from the current stage contents.
    always_comb begin
        ld_stall_s   = MemtoRegE & ((RA1D == wa3_e_r) | (RA2D == wa3_e_r));
        pc_wr_pend_s = PCSrcD | PCSrcE | PCSrcM;
        flush_e_s    = ld_stall_s | BranchTakenE;
        StallF       = ld_stall_s | pc_wr_pend_s;
        StallD       = ld_stall_s;
        FlushD       = pc_wr_pend_s | PCSrcW | BranchTakenE;
        FlushE       = flush_e_s;
        ForwardAE    = fwd_sel(ra1_e_r, wa3_m_r, wa3_w_r, RegWriteM, RegWriteW);
        ForwardBE    = fwd_sel(ra2_e_r, wa3_m_r, wa3_w_r, RegWriteM, RegWriteW);
    end

    // Address pipeline; a stalled slot is always flushed, so no hold path is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra1_e_r <= {RA_W{1'b0}};
            ra2_e_r <= {RA_W{1'b0}};
            wa3_e_r <= {RA_W{1'b0}};
            wa3_m_r <= {RA_W{1'b0}};
            wa3_w_r <= {RA_W{1'b0}};
        end else begin
            if (flush_e_s) begin
                ra1_e_r <= {RA_W{1'b0}};
                ra2_e_r <= {RA_W{1'b0}};
                wa3_e_r <= {RA_W{1'b0}};
            end else begin
                ra1_e_r <= RA1D;
                ra2_e_r <= RA2D;
                wa3_e_r <= WA3D;
            end
            wa3_m_r <= wa3_e_r;
            wa3_w_r <= wa3_m_r;
        end
    end

    // Saturating event counters for load-use stalls and taken branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_stall_cnt_r <= {CNT_W{1'b0}};
            br_flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ld_stall_s) begin
                ld_stall_cnt_r <= sat_inc(ld_stall_cnt_r);
            end else begin
                ld_stall_cnt_r <= ld_stall_cnt_r;
            end
            if (BranchTakenE) begin
                br_flush_cnt_r <= sat_inc(br_flush_cnt_r);
            end else begin
                br_flush_cnt_r <= br_flush_cnt_r;
            end
        end
    end

    assign LdStallCount = ld_stall_cnt_r;
    assign BrFlushCount = br_flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        RegWriteM, RegWriteW, MemtoRegE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] LdStallCount, BrFlushCount;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_unit #(.RA_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .LdStallCount(LdStallCount), .BrFlushCount(BrFlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = 4'd0; RA2D = 4'd0; WA3D = 4'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        check("rst_fwd_a", {30'd0, ForwardAE}, 32'd0);
        check("rst_stall_f", {31'd0, StallF}, 32'd0);
        check("rst_flush_d", {31'd0, FlushD}, 32'd0);
        check("rst_ld_cnt", {16'd0, LdStallCount}, 32'd0);
        do_reset();

        // 1: ADD R1 then SUB R2,R1
        WA3D = 4'd1; tick();
        RA1D = 4'd1; WA3D = 4'd2; tick();
        RegWriteM = 1'b1; #1;
        check("t1_fwd_a", {30'd0, ForwardAE}, 32'd2);
        check("t1_stall_f", {31'd0, StallF}, 32'd0);
        clear_inputs();

        // 2: R1 in both M and W
        do_reset();
        RA1D = 4'd1; WA3D = 4'd1;
        tick(); tick(); tick();
        RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        check("t2_fwd_a_m", {30'd0, ForwardAE}, 32'd2);
        RegWriteM = 1'b0; #1;
        check("t2_fwd_a_w", {30'd0, ForwardAE}, 32'd1);
        RegWriteW = 1'b0; #1;
        check("t2_fwd_a_none", {30'd0, ForwardAE}, 32'd0);

        // ForwardBE via RA2
        do_reset();
        RA2D = 4'd4; WA3D = 4'd4;
        tick(); tick(); tick();
        RegWriteW = 1'b1; #1;
        check("t2_fwd_b_w", {30'd0, ForwardBE}, 32'd1);
        check("t2_fwd_a_r0", {30'd0, ForwardAE}, 32'd0);
        clear_inputs();

        // 3: LDR R3 in E, RA2D=3
        do_reset();
        WA3D = 4'd3; RA2D = 4'd3; tick();
        check("t3_no_stall_pre", {31'd0, StallD}, 32'd0);
        MemtoRegE = 1'b1; WA3D = 4'd5; #1;
        check("t3_stall_f", {31'd0, StallF}, 32'd1);
        check("t3_stall_d", {31'd0, StallD}, 32'd1);
        check("t3_flush_e", {31'd0, FlushE}, 32'd1);
        tick();
        MemtoRegE = 1'b0; #1;
        check("t3_ra2e_zero", {28'd0, dut.ra2_e_r}, 32'd0);
        check("t3_ld_cnt", {16'd0, LdStallCount}, 32'd1);
        check("t3_stall_off", {31'd0, StallF}, 32'd0);

        // 4: branch taken one cycle
        BranchTakenE = 1'b1; #1;
        check("t4_flush_d", {31'd0, FlushD}, 32'd1);
        check("t4_flush_e", {31'd0, FlushE}, 32'd1);
        check("t4_stall_f", {31'd0, StallF}, 32'd0);
        tick();
        BranchTakenE = 1'b0; #1;
        check("t4_br_cnt", {16'd0, BrFlushCount}, 32'd1);
        check("t4_flush_d_off", {31'd0, FlushD}, 32'd0);

        // Load-use stall and branch together: both counters step
        WA3D = 4'd6; tick();
        MemtoRegE = 1'b1; RA1D = 4'd6; BranchTakenE = 1'b1; #1;
        check("sim_flush_e", {31'd0, FlushE}, 32'd1);
        tick();
        clear_inputs(); #1;
        check("sim_wa3e_zero", {28'd0, dut.wa3_e_r}, 32'd0);
        check("sim_ld_cnt", {16'd0, LdStallCount}, 32'd2);
        check("sim_br_cnt", {16'd0, BrFlushCount}, 32'd2);

        // 5: PC write walking D->E->M->W
        PCSrcD = 1'b1; #1;
        check("t5_stall_f_d", {31'd0, StallF}, 32'd1);
        tick(); PCSrcD = 1'b0; PCSrcE = 1'b1; #1;
        check("t5_stall_f_e", {31'd0, StallF}, 32'd1);
        tick(); PCSrcE = 1'b0; PCSrcM = 1'b1; #1;
        check("t5_stall_f_m", {31'd0, StallF}, 32'd1);
        tick(); PCSrcM = 1'b0; PCSrcW = 1'b1; #1;
        check("t5_stall_f_w", {31'd0, StallF}, 32'd0);
        check("t5_flush_d_w", {31'd0, FlushD}, 32'd1);
        tick(); PCSrcW = 1'b0; #1;
        check("t5_flush_d_after", {31'd0, FlushD}, 32'd0);

        // 6: saturate LdStallCount (WA3E stays 0, RA1D=0 keeps stalling)
        do_reset();
        MemtoRegE = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("t6_ld_cnt_max", {16'd0, LdStallCount}, 32'h0000_FFFF);
        tick();
        check("t6_ld_cnt_sat", {16'd0, LdStallCount}, 32'h0000_FFFF);

        // Reset mid-stall with WA3E non-zero
        MemtoRegE = 1'b0; RA1D = 4'd7; RA2D = 4'd7; WA3D = 4'd7; tick();
        MemtoRegE = 1'b1; #1;
        check("t6_stall_pre_rst", {31'd0, StallD}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_stall_f", {31'd0, StallF}, 32'd0);
        check("t6_rst_flush_e", {31'd0, FlushE}, 32'd0);
        check("t6_rst_ld_cnt", {16'd0, LdStallCount}, 32'd0);
        check("t6_rst_wa3e", {28'd0, dut.wa3_e_r}, 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();
        check("t6_post_stall_f", {31'd0, StallF}, 32'd0);
        check("t6_post_ld_cnt", {16'd0, LdStallCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
